fetch_sequencer: RTL and testbench

- Control block for the instruction-fetch stage.
- Selects the next-PC source (the 3-bit dir_sl select of the PC mux: sequential/jump/branch) and gates PC and IF/ID register writes.
- Generates pipeline flushes on redirects and inserts bubbles on hazard stalls and instruction-memory wait cycles.
- Sits between the hazard unit, decode (jump), execute (branch resolution), the PC mux/PC register and the IF/ID register.

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_perf_counter.sv | 21 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the PC mux:
// next-PC select codes, the sequencer state type and the bubble-counter width.
package fetch_pkg;

    localparam int PC_SEL_W = 3;
    localparam int BUB_W    = 3;

    typedef logic [PC_SEL_W-1:0] pc_sel_t;

    localparam pc_sel_t SEL_SEQ    = 3'b000;
    localparam pc_sel_t SEL_JUMP   = 3'b001;
    localparam pc_sel_t SEL_BRANCH = 3'b010;

    typedef enum logic [2:0] {
        S_RESET,
        S_RUN,
        S_STALL,
        S_WAIT,
        S_FLUSH
    } fetch_state_t;

    // A redirect with no extra bubbles to run goes straight back to S_RUN.
    function automatic fetch_state_t redirect_state(input logic [BUB_W-1:0] reload);
        return (reload == '0) ? S_RUN : S_FLUSH;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Request/control bundle between the fetch sequencer (slave) and the
// surrounding pipeline: hazard unit, decode, execute, PC mux and IF/ID.
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
) ();
    import fetch_pkg::*;

    logic             branch_req;
    logic             jump_req;
    logic             stall_req;
    logic             imem_ready;
    pc_sel_t          dir_sl;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             fetch_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport slave (
        input  branch_req, jump_req, stall_req, imem_ready,
        output dir_sl, pc_we, ifid_we, ifid_flush, idex_flush, fetch_valid,
        output stall_cnt, redirect_cnt
    );

    modport master (
        output branch_req, jump_req, stall_req, imem_ready,
        input  dir_sl, pc_we, ifid_we, ifid_flush, idex_flush, fetch_valid,
        input  stall_cnt, redirect_cnt
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// Saturating event counter with synchronous active-high clear.
module fetch_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count qualified events, sticking at all-ones.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: next-PC select, PC/IF-ID write gating,
// redirect flushes and stall/memory-wait bubbles.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise stall_cnt/redirect_cnt are tied to zero.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.slave  bus
);

    localparam logic [BUB_W-1:0] RELOAD = BUB_W'(REDIRECT_BUBBLES - 1);

    fetch_state_t     state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic             valid_q;

    // Output decode and next-state selection, by request priority.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        bus.dir_sl      = SEL_SEQ;
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.fetch_valid = 1'b1;
        state_d         = S_RUN;
        bub_d           = '0;

        if (rst || (state_q == S_RESET)) begin
            bus.pc_we       = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
            state_d         = rst ? S_RESET : S_RUN;
        end else if (bus.branch_req) begin
            // Younger stall/jump requests are squashed along with their instructions.
            bus.dir_sl      = SEL_BRANCH;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
            state_d         = redirect_state(RELOAD);
            bub_d           = RELOAD;
        end else if (state_q == S_FLUSH) begin
            // ID holds a bubble, so its stall/jump requests are meaningless here.
            bus.ifid_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
            if (bub_q > BUB_W'(1)) begin
                state_d = S_FLUSH;
                bub_d   = bub_q - BUB_W'(1);
            end
        end else if (bus.stall_req) begin
            // A jump in the stalled ID stage waits until the stall clears.
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_flush  = 1'b1;
            bus.fetch_valid = valid_q;
            state_d         = S_STALL;
        end else if (bus.jump_req) begin
            bus.dir_sl      = SEL_JUMP;
            bus.ifid_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
            state_d         = redirect_state(RELOAD);
            bub_d           = RELOAD;
        end else if (!bus.imem_ready) begin
            bus.pc_we       = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
            state_d         = S_WAIT;
        end
    end

    // State, bubble counter and last-cycle fetch_valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            bub_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            valid_q <= bus.fetch_valid;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_inc;
    logic redirect_inc;

    assign stall_inc    = !rst && (state_q != S_RESET) && !bus.pc_we;
    assign redirect_inc = (bus.dir_sl != SEL_SEQ);

    fetch_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (bus.stall_cnt)
    );

    fetch_perf_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect_inc),
        .cnt (bus.redirect_cnt)
    );
`else
    assign bus.stall_cnt    = {CNT_W{1'b0}};
    assign bus.redirect_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with REDIRECT_BUBBLES=2 and CNT_W=4.
// Counter checks follow FETCH_PERF_CNT_EN.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int CNT_W = 4;

    // Stimulus word {rst, branch, jump, stall, imem_ready}
    localparam logic [4:0] RSTV  = 5'b10001;
    localparam logic [4:0] IDLE  = 5'b00001;
    localparam logic [4:0] BR    = 5'b01001;
    localparam logic [4:0] JMP   = 5'b00101;
    localparam logic [4:0] STL   = 5'b00011;
    localparam logic [4:0] STJ   = 5'b00111;
    localparam logic [4:0] BRST  = 5'b01011;
    localparam logic [4:0] NRDY  = 5'b00000;
    localparam logic [4:0] BRNR  = 5'b01000;

    // Expected {dir_sl, pc_we, ifid_we, ifid_flush, idex_flush, fetch_valid}
    localparam logic [7:0] O_RST  = 8'b000_0_1_1_1_0;
    localparam logic [7:0] O_RUN  = 8'b000_1_1_0_0_1;
    localparam logic [7:0] O_BR   = 8'b010_1_1_1_1_0;
    localparam logic [7:0] O_JMP  = 8'b001_1_1_1_0_0;
    localparam logic [7:0] O_FL   = 8'b000_1_1_1_0_0;
    localparam logic [7:0] O_ST1  = 8'b000_0_0_0_1_1;
    localparam logic [7:0] O_ST0  = 8'b000_0_0_0_1_0;
    localparam logic [7:0] O_WAIT = 8'b000_0_1_1_0_0;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] obs;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    fetch_sequencer #(.REDIRECT_BUBBLES(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign obs = {bus.dir_sl, bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush, bus.fetch_valid};

    // Apply one cycle of stimulus just after the edge, return at the falling edge for sampling.
    task automatic step(input logic [4:0] s);
        @(posedge clk);
        #1;
        {rst, bus.branch_req, bus.jump_req, bus.stall_req, bus.imem_ready} = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [4:0] st [6] = '{RSTV, RSTV, RSTV, IDLE, IDLE, IDLE};
        logic [7:0] ex [6] = '{O_RST, O_RST, O_RST, O_RST, O_RUN, O_RUN};
        for (int i = 0; i < 6; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_branch;
        logic [4:0] st [3] = '{BR, IDLE, IDLE};
        logic [7:0] ex [3] = '{O_BR, O_FL, O_RUN};
        for (int i = 0; i < 3; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_stall_jump;
        logic [4:0] st [6] = '{STJ, STJ, STJ, JMP, IDLE, IDLE};
        logic [7:0] ex [6] = '{O_ST1, O_ST1, O_ST1, O_JMP, O_FL, O_RUN};
        for (int i = 0; i < 6; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL stall_jump[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_branch_beats_stall;
        logic [4:0] st [3] = '{BRST, IDLE, IDLE};
        logic [7:0] ex [3] = '{O_BR, O_FL, O_RUN};
        for (int i = 0; i < 3; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL branch_beats_stall[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_mem_wait;
        logic [4:0] st [11] = '{NRDY, NRDY, NRDY, NRDY, IDLE, NRDY, NRDY, BRNR, IDLE, IDLE, IDLE};
        logic [7:0] ex [11] = '{O_WAIT, O_WAIT, O_WAIT, O_WAIT, O_RUN,
                                O_WAIT, O_WAIT, O_BR, O_FL, O_RUN, O_RUN};
        for (int i = 0; i < 11; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    // Stall/jump ignored in S_FLUSH, fetch_valid held through a stall, branch reloads the counter.
    task automatic test_flush_rules;
        logic [4:0] st [11] = '{BR, STL, STL, IDLE, BR, JMP, IDLE, BR, BR, IDLE, IDLE};
        logic [7:0] ex [11] = '{O_BR, O_FL, O_ST0, O_RUN, O_BR, O_FL, O_RUN,
                                O_BR, O_BR, O_FL, O_RUN};
        for (int i = 0; i < 11; i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL flush_rules[%0d]: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        step(STJ);
        step(5'b11111);
        step(IDLE);
        checks++;
        if (obs !== O_RST) begin
            errors++;
            $display("FAIL mid_reset_state: got %b expected %b", obs, O_RST);
        end
        step(IDLE);
        checks++;
        if (obs !== O_RUN) begin
            errors++;
            $display("FAIL mid_reset_run: got %b expected %b", obs, O_RUN);
        end
    endtask

    task automatic test_counters;
        logic [CNT_W-1:0] exp_stall;
        logic [CNT_W-1:0] exp_redir;
        step(RSTV);
        step(IDLE);
        for (int i = 0; i < 20; i++) step(STL);
        step(IDLE);
`ifdef FETCH_PERF_CNT_EN
        exp_stall = 4'd15;
`else
        exp_stall = 4'd0;
`endif
        exp_redir = 4'd0;
        checks++;
        if (bus.stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL stall_cnt_sat: got %0d expected %0d", bus.stall_cnt, exp_stall);
        end
        step(BR);
        step(IDLE);
`ifdef FETCH_PERF_CNT_EN
        exp_redir = 4'd1;
`endif
        checks++;
        if (bus.redirect_cnt !== exp_redir) begin
            errors++;
            $display("FAIL redirect_cnt_branch: got %0d expected %0d", bus.redirect_cnt, exp_redir);
        end
        step(IDLE);
        step(JMP);
        step(IDLE);
`ifdef FETCH_PERF_CNT_EN
        exp_redir = 4'd2;
`endif
        checks++;
        if (bus.redirect_cnt !== exp_redir) begin
            errors++;
            $display("FAIL redirect_cnt_jump: got %0d expected %0d", bus.redirect_cnt, exp_redir);
        end
        step(RSTV);
        step(IDLE);
        checks++;
        if ({bus.stall_cnt, bus.redirect_cnt} !== {2*CNT_W{1'b0}}) begin
            errors++;
            $display("FAIL cnt_clear: got stall=%0d redirect=%0d expected 0 0",
                     bus.stall_cnt, bus.redirect_cnt);
        end
        checks++;
        if (obs !== O_RST) begin
            errors++;
            $display("FAIL cnt_reset_state: got %b expected %b", obs, O_RST);
        end
    endtask

    initial begin
        {rst, bus.branch_req, bus.jump_req, bus.stall_req, bus.imem_ready} = RSTV;
        repeat (2) @(posedge clk);
        test_reset();
        test_branch();
        test_stall_jump();
        test_branch_beats_stall();
        test_mem_wait();
        test_flush_rules();
        test_mid_reset();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
